// File: rtl/mips_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM states, trap
// cause codes, default vectors and a word-alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXC  = 2'd1;
  localparam logic [1:0] CAUSE_IRQ  = 2'd2;
  localparam logic [1:0] CAUSE_ADDR = 2'd3;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int          DEF_BOOT_CYCLES  = 2;

  // Branch and jump targets are silently word-aligned rather than trapped.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_reg_en.sv
// 32-bit register with load enable and a parameterised synchronous
// active-high reset value; used for both the PC and the EPC.
module pc_reg_en #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: combinational next-PC selection, boot hold, and a
// minimal trap unit (EPC, cause, handler mode, sticky double fault).
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        irq,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        in_handler,
  output logic        double_fault,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] BOOT_INIT = 16'(BOOT_CYCLES - 1);

  seq_state_t  r_state;
  logic [15:0] r_boot_cnt;
  logic [1:0]  r_cause;
  logic        r_double_fault;
  logic        r_fetch_valid;
  logic        r_in_handler;

  logic [31:0] w_pc;
  logic [31:0] w_epc;
  logic [31:0] w_pc_plus4;
  logic        w_jr_mis;
  logic        w_active;
  logic [31:0] w_seq_next;
  logic        w_take_trap;
  logic        w_take_eret;
  logic [1:0]  w_trap_code;
  logic [31:0] w_pc_next;
  logic        w_pc_en;
  logic [31:0] w_epc_next;
  logic        w_epc_en;

  assign w_pc_plus4 = w_pc + 32'd4;
  assign w_jr_mis   = jr && (jr_target[1:0] != 2'b00);
  // Stall only freezes the core once it is out of BOOT; BOOT ignores it.
  assign w_active   = (r_state != BOOT) && !stall;

  always_comb begin
    w_seq_next = w_pc_plus4;
    if (jr && !w_jr_mis) begin
      w_seq_next = jr_target;
    end else if (jump) begin
      w_seq_next = align_word(jump_target);
    end else if (branch_taken) begin
      w_seq_next = align_word(branch_target);
    end
  end

  // Trap/eret arbitration; irq is masked in HANDLER and eret is ignored in RUN.
  always_comb begin
    w_take_trap = 1'b0;
    w_take_eret = 1'b0;
    w_trap_code = CAUSE_NONE;
    if (r_state == RUN) begin
      if (exc_req) begin
        w_take_trap = 1'b1;
        w_trap_code = CAUSE_EXC;
      end else if (w_jr_mis) begin
        w_take_trap = 1'b1;
        w_trap_code = CAUSE_ADDR;
      end else if (irq) begin
        w_take_trap = 1'b1;
        w_trap_code = CAUSE_IRQ;
      end
    end else if (r_state == HANDLER) begin
      if (exc_req) begin
        w_take_trap = 1'b1;
        w_trap_code = CAUSE_EXC;
      end else if (eret) begin
        w_take_eret = 1'b1;
      end else if (w_jr_mis) begin
        w_take_trap = 1'b1;
        w_trap_code = CAUSE_ADDR;
      end
    end
  end

  always_comb begin
    w_pc_next = w_seq_next;
    if (w_take_trap) begin
      w_pc_next = EXC_VECTOR;
    end else if (w_take_eret) begin
      w_pc_next = w_epc;
    end
    w_pc_en = w_active;
    // An interrupted instruction completes, so it resumes at its successor.
    w_epc_next = (w_trap_code == CAUSE_IRQ) ? w_seq_next : w_pc;
    w_epc_en   = w_active && w_take_trap && (r_state == RUN);
  end

  pc_reg_en #(.RESET_VAL(RESET_VECTOR)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_pc_en),
    .d     (w_pc_next),
    .q     (w_pc)
  );

  pc_reg_en #(.RESET_VAL(32'h0000_0000)) u_epc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_epc_en),
    .d     (w_epc_next),
    .q     (w_epc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= BOOT;
      r_boot_cnt     <= BOOT_INIT;
      r_cause        <= CAUSE_NONE;
      r_double_fault <= 1'b0;
      r_fetch_valid  <= 1'b0;
      r_in_handler   <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          if (r_boot_cnt == 16'd0) begin
            r_state       <= RUN;
            r_fetch_valid <= 1'b1;
          end else begin
            r_boot_cnt <= r_boot_cnt - 16'd1;
          end
        end
        RUN: begin
          if (w_active && w_take_trap) begin
            r_state      <= HANDLER;
            r_in_handler <= 1'b1;
            r_cause      <= w_trap_code;
          end
        end
        HANDLER: begin
          if (w_active && w_take_trap) begin
            r_double_fault <= 1'b1;
          end else if (w_active && w_take_eret) begin
            r_state      <= RUN;
            r_in_handler <= 1'b0;
          end
        end
        default: begin
          r_state       <= BOOT;
          r_boot_cnt    <= BOOT_INIT;
          r_fetch_valid <= 1'b0;
          r_in_handler  <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = w_pc;
  assign pc_plus4     = w_pc_plus4;
  assign epc          = w_epc;
  assign cause        = r_cause;
  assign fetch_valid  = r_fetch_valid;
  assign in_handler   = r_in_handler;
  assign double_fault = r_double_fault;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0080;
  localparam int          BC = 2;
  localparam int          EW = 101;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HND  = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        irq;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        in_handler;
  logic        double_fault;
  logic [1:0]  dbg_state;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .BOOT_CYCLES  (BC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .irq           (irq),
    .eret          (eret),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .epc           (epc),
    .cause         (cause),
    .in_handler    (in_handler),
    .double_fault  (double_fault),
    .dbg_state     (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;
  logic        m_df;
  int          m_mode;
  int          m_boot_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_trap(input logic [1:0] code, input logic [31:0] ret);
    if (m_mode == M_RUN) begin
      m_epc   = ret;
      m_cause = code;
      m_mode  = M_HND;
    end else begin
      m_df = 1'b1;
    end
    m_pc = EV;
  endtask

  task automatic model_step();
    logic        mis;
    logic [31:0] seq;
    if (reset) begin
      m_pc = RV; m_epc = 32'd0; m_cause = 2'd0; m_df = 1'b0;
      m_mode = M_BOOT; m_boot_seen = 1;
    end else if (m_mode == M_BOOT) begin
      if (m_boot_seen >= BC) m_mode = M_RUN;
      else m_boot_seen++;
    end else if (!stall) begin
      mis = jr && (jr_target % 4 != 0);
      if (jr && !mis)        seq = jr_target;
      else if (jump)         seq = jump_target & ~32'd3;
      else if (branch_taken) seq = branch_target & ~32'd3;
      else                   seq = m_pc + 32'd4;
      if (m_mode == M_RUN) begin
        if (exc_req)  model_trap(2'd1, m_pc);
        else if (mis) model_trap(2'd3, m_pc);
        else if (irq) model_trap(2'd2, seq);
        else          m_pc = seq;
      end else begin
        if (exc_req) model_trap(2'd1, m_pc);
        else if (eret) begin
          m_pc = m_epc;
          m_mode = M_RUN;
        end
        else if (mis) model_trap(2'd3, m_pc);
        else          m_pc = seq;
      end
    end
    exp_q.push_back({m_mode != M_BOOT, m_mode == M_HND, m_df, m_cause,
                     m_epc, m_pc + 32'd4, m_pc});
  endtask

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic clear_req();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0; jr = 1'b0; jr_target = 32'd0;
    exc_req = 1'b0; irq = 1'b0; eret = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    clear_req();
  endtask

  task automatic go_to(input logic [31:0] a);
    jump = 1'b1; jump_target = a; tick();
  endtask

  // Monitor: one expected entry per rising edge, compared 1 unit after it.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           pc,                    e[31:0]);
        chk("pc_plus4",     pc_plus4,              e[63:32]);
        chk("epc",          epc,                   e[95:64]);
        chk("cause",        {30'd0, cause},        {30'd0, e[97:96]});
        chk("double_fault", {31'd0, double_fault}, {31'd0, e[98]});
        chk("in_handler",   {31'd0, in_handler},   {31'd0, e[99]});
        chk("fetch_valid",  {31'd0, fetch_valid},  {31'd0, e[100]});
      end
    end
  end

  // Stimulus
  initial begin
    clear_req();
    #2;
    reset = 1'b1; tick();
    tick(); tick(); tick(); tick();

    go_to(32'h40);
    branch_taken = 1'b1; branch_target = 32'h104; jump = 1'b1; jump_target = 32'h200; tick();
    branch_taken = 1'b1; branch_target = 32'h103; tick();

    go_to(32'h10);
    exc_req = 1'b1; tick();
    tick();
    eret = 1'b1; tick();

    go_to(32'h20);
    irq = 1'b1; jump = 1'b1; jump_target = 32'h300; tick();
    irq = 1'b1; tick();
    jr = 1'b1; jr_target = 32'h305; tick();
    eret = 1'b1; tick();

    go_to(32'h50);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; jump = 1'b1; jump_target = 32'h60; tick();
    end
    tick();

    go_to(32'hFFFF_FFFC);
    tick();

    jr = 1'b1; jr_target = 32'h1002; tick();
    reset = 1'b1; irq = 1'b1; jump = 1'b1; jump_target = 32'h400; tick();
    tick(); tick(); tick();

    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 9) == 0);
      exc_req       = ($urandom_range(0, 19) == 0);
      irq           = ($urandom_range(0, 14) == 0);
      eret          = ($urandom_range(0, 5) == 0);
      jr            = ($urandom_range(0, 11) == 0);
      jr_target     = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target = jr_target & ~32'd3;
      jump          = ($urandom_range(0, 7) == 0);
      jump_target   = $urandom;
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      tick();
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
